// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants for the UART receiver: register offsets, STATUS bits, FSM states
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Word offsets, compared against mem_addr[3:2]
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_NEMPTY  = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_FERR    = 2;
    localparam int STAT_IRQ     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 9;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - CPU memory-bus slice seen by the UART receiver
interface uart_rx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - power-of-two receive FIFO; a push while full is accepted only alongside a pop
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with RX FIFO and RXDATA/STATUS registers on the CPU bus
// Optional UART_RX_IRQ_EN adds the registered rx_irq output and STATUS bit3.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     serialIn,
`ifdef UART_RX_IRQ_EN
    output logic     rx_irq,
`endif
    uart_rx_if.slave bus
);
    localparam int CW  = $clog2(BAUD_DIV);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    logic          w_rx;
    rx_state_t     r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [2:0]    r_bit, w_bit_next;
    logic          r_stop_wait, w_stop_wait_next;
    logic          w_expired, w_push, w_ferr_set;

    logic          r_ready, r_ovr, r_ferr;
    logic [31:0]   r_rdata;
    logic          w_req, w_wr, w_pop, w_full, w_empty, w_ovr_set, w_clr_ovr, w_clr_ferr;
    logic [1:0]    w_reg;
    logic [7:0]    w_dout;
    logic [FCW-1:0] w_count;
    logic [31:0]   w_status, w_rdata;
    logic          w_unused_bits;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= 2'b11;
            r_prev      <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            r_stop_wait <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], serialIn};
            r_prev      <= w_rx;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_bit       <= w_bit_next;
            r_stop_wait <= w_stop_wait_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_expired        = (r_cnt == '0);
        w_cnt_next       = w_expired ? r_cnt : r_cnt - 1'b1;
        w_shift_next     = r_shift;
        w_bit_next       = r_bit;
        w_stop_wait_next = r_stop_wait;
        w_push           = 1'b0;
        w_ferr_set       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_prev && !w_rx) begin
                w_state_next = ST_START;
                w_cnt_next   = CNT_HALF;
            end
            ST_START: if (w_expired) begin
                if (!w_rx) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = CNT_FULL;
                    w_bit_next   = '0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: if (w_expired) begin
                w_shift_next = {w_rx, r_shift[7:1]};
                w_cnt_next   = CNT_FULL;
                w_bit_next   = r_bit + 3'd1;
                if (r_bit == 3'd7) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // After a framing error, hold here until the line returns to idle
                if (r_stop_wait) begin
                    if (w_rx) begin
                        w_state_next     = ST_IDLE;
                        w_stop_wait_next = 1'b0;
                    end
                end else if (w_expired) begin
                    if (w_rx) begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr_set       = 1'b1;
                        w_stop_wait_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_req      = bus.mem_valid & bus.enable & ~r_ready;
    assign w_wr       = |bus.mem_wstrb;
    assign w_reg      = bus.mem_addr[3:2];
    assign w_pop      = w_req & ~w_wr & (w_reg == REG_RXDATA) & ~w_empty;
    assign w_ovr_set  = w_push & w_full & ~w_pop;
    assign w_clr_ovr  = w_req & w_wr & (w_reg == REG_STATUS) & bus.mem_wstrb[0] & bus.mem_wdata[STAT_OVR];
    assign w_clr_ferr = w_req & w_wr & (w_reg == REG_STATUS) & bus.mem_wstrb[0] & bus.mem_wdata[STAT_FERR];
    assign w_unused_bits = ^{bus.mem_instr, bus.mem_wdata[31:3], bus.mem_wdata[0],
                             bus.mem_addr[31:4], bus.mem_addr[1:0]};

    always_comb begin
        w_status                                = '0;
        w_status[STAT_NEMPTY]                   = ~w_empty;
        w_status[STAT_OVR]                      = r_ovr;
        w_status[STAT_FERR]                     = r_ferr;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(w_count);
`ifdef UART_RX_IRQ_EN
        w_status[STAT_IRQ]                      = rx_irq;
`endif
        w_rdata = '0;
        if (w_reg == REG_RXDATA && !w_empty) w_rdata = {24'h0, w_dout};
        else if (w_reg == REG_STATUS)        w_rdata = w_status;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= w_req;
            r_rdata <= (w_req && !w_wr) ? w_rdata : '0;
            r_ovr   <= (r_ovr  & ~w_clr_ovr)  | w_ovr_set;
            r_ferr  <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
        end
    end

`ifdef UART_RX_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= ~w_empty | r_ovr | r_ferr;
    end
    assign rx_irq = r_irq;
`endif

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a queue-based receive model
module tb_uart_rx;
    localparam int BD    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic serialIn;
`ifdef UART_RX_IRQ_EN
    logic rx_irq;
`endif
    uart_rx_if bus();

    uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .serialIn (serialIn),
`ifdef UART_RX_IRQ_EN
        .rx_irq   (rx_irq),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    byte unsigned q[$];
    bit m_ovr, m_ferr;

    logic        exp_ack      = 1'b0;
    logic        exp_chk_data = 1'b0;
    logic [31:0] exp_data     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = (q.size() != 0);
        s[1] = m_ovr;
        s[2] = m_ferr;
`ifdef UART_RX_IRQ_EN
        s[3] = s[0] | s[1] | s[2];
`endif
        s[16:8] = 9'(q.size());
        return s;
    endfunction

    // Bus access: model decides the response at request time; compare process checks it in the ack cycle
    task automatic bus_xfer(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] wd,
                            input logic en, output logic [31:0] rd);
        logic [31:0] e;
        e = '0;
        if (en && strb == 4'h0) begin
            if (off == 4'h0) e = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
            else if (off == 4'h4) e = model_status();
        end else if (en && off == 4'h4 && strb[0]) begin
            if (wd[1]) m_ovr  = 1'b0;
            if (wd[2]) m_ferr = 1'b0;
        end
        bus.enable    = en;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {28'h0, off};
        bus.mem_wstrb = strb;
        bus.mem_wdata = wd;
        tick(1);
        bus.mem_valid = 1'b0;
        bus.enable    = 1'b0;
        bus.mem_wstrb = 4'h0;
        exp_ack       = en;
        exp_chk_data  = (strb == 4'h0);
        exp_data      = e;
        rd            = bus.mem_rdata;
        tick(1);
        exp_ack       = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        serialIn = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            tick(BD);
        end
        serialIn = stop_ok;
        tick(BD);
        if (!stop_ok) tick(40 - BD);
        serialIn = 1'b1;
        tick(BD);
        if (!stop_ok)                 m_ferr = 1'b1;
        else if (q.size() < DEPTH)    q.push_back(b);
        else                          m_ovr = 1'b1;
    endtask

    always @(negedge clk) begin
        check("mem_ready", {31'h0, bus.mem_ready}, {31'h0, exp_ack});
        if (!exp_ack)          check("mem_rdata_idle", bus.mem_rdata, 32'h0);
        else if (exp_chk_data) check("mem_rdata", bus.mem_rdata, exp_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        reset         = 1'b1;
        serialIn      = 1'b1;
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = '0;
        bus.mem_addr  = '0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("reset_status", rd, 32'h0);

        send_frame(8'hA5, 1'b1);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("a5_status", rd, 32'h0000_0101);
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("a5_data", rd, 32'h0000_00A5);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("a5_status_after", rd, 32'h0);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ovr_status", rd, 32'h0000_0403);
        for (int i = 1; i <= 4; i++) begin
            bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("ovr_data", rd, 32'(i));
        end
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("empty_read", rd, 32'h0);
        bus_xfer(4'h4, 4'h1, 32'h2, 1'b1, rd);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ovr_cleared", rd, 32'h0);

        send_frame(8'h3C, 1'b0);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ferr_status", rd, 32'h0000_0004);
        bus_xfer(4'h4, 4'h2, 32'h4, 1'b1, rd);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ferr_no_strb0", rd, 32'h0000_0004);
        bus_xfer(4'h0, 4'h1, 32'h4, 1'b1, rd);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ferr_rxdata_wr", rd, 32'h0000_0004);
        bus_xfer(4'h4, 4'h1, 32'h4, 1'b1, rd);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("ferr_cleared", rd, 32'h0);

        serialIn = 1'b0;
        tick(4);
        serialIn = 1'b1;
        tick(40);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("glitch_status", rd, 32'h0);
        send_frame(8'h5A, 1'b1);
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("after_glitch", rd, 32'h0000_005A);

        send_frame(8'h11, 1'b1);
        bus_xfer(4'h0, 4'h0, 0, 1'b0, rd);  check("disabled_rdata", rd, 32'h0);
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("enabled_no_pop", rd, 32'h0000_0011);

        serialIn = 1'b0;
        tick(BD);
        for (int i = 0; i < 4; i++) begin
            serialIn = (i % 2 == 0);
            tick(BD);
        end
        serialIn = 1'b1;
        tick(BD / 2);
        reset = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("post_reset_status", rd, 32'h0);
        send_frame(8'h66, 1'b1);
        bus_xfer(4'h4, 4'h0, 0, 1'b1, rd);  check("reset_frame_status", rd, 32'h0000_0101);
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("reset_frame_data", rd, 32'h0000_0066);
        bus_xfer(4'h0, 4'h0, 0, 1'b1, rd);  check("reset_frame_empty", rd, 32'h0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
